// File: rtl/jpeg_unpack_pkg.sv
// rtl/jpeg_unpack_pkg.sv - shared types and constants for the JPEG bitstream unpacker
package jpeg_unpack_pkg;

   typedef enum logic [1:0] {
      S_DATA   = 2'd0,
      S_FF     = 2'd1,
      S_MARKER = 2'd2
   } state_t;

   localparam logic [7:0] MARKER_PFX = 8'hFF;
   localparam logic [7:0] STUFF_BYTE = 8'h00;

   localparam int PEEK_W_DEF = 16;
   localparam int BUF_W_DEF  = 32;
   localparam int CNT_W_DEF  = 6;

endpackage

// File: rtl/jpeg_unstuff_fsm.sv
// rtl/jpeg_unstuff_fsm.sv - byte handshake, 0xFF00 unstuffing and marker detection
// Optional JPEG_UNPACK_STATS_EN adds saturating stuff/fill byte counters.
module jpeg_unstuff_fsm
   import jpeg_unpack_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       rx_en,
   input  logic       marker_clr,
   output logic       in_ready,
   output logic       app_valid,
   output logic [7:0] app_byte,
   output logic       marker_found,
`ifdef JPEG_UNPACK_STATS_EN
   output logic [15:0] stuff_cnt,
   output logic [15:0] fill_cnt,
`endif
   output logic [7:0] marker_code
);

   state_t state_q;
   logic   accept;

   assign in_ready = rx_en && (state_q != S_MARKER);
   assign accept   = in_valid && in_ready;

   // A stuffed pair always yields 0xFF, regardless of the byte actually on the bus.
   always_comb begin
      app_valid = 1'b0;
      app_byte  = in_data;
      if (accept) begin
         case (state_q)
            S_DATA: app_valid = (in_data != MARKER_PFX);
            S_FF: begin
               app_valid = (in_data == STUFF_BYTE);
               app_byte  = MARKER_PFX;
            end
            default: app_valid = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_DATA;
         marker_found <= 1'b0;
         marker_code  <= 8'h00;
      end else begin
         case (state_q)
            S_DATA: begin
               if (accept && in_data == MARKER_PFX) state_q <= S_FF;
            end
            S_FF: begin
               if (accept) begin
                  if (in_data == STUFF_BYTE) begin
                     state_q <= S_DATA;
                  end else if (in_data != MARKER_PFX) begin
                     state_q      <= S_MARKER;
                     marker_found <= 1'b1;
                     marker_code  <= in_data;
                  end
               end
            end
            S_MARKER: begin
               if (marker_clr) begin
                  state_q      <= S_DATA;
                  marker_found <= 1'b0;
               end
            end
            default: state_q <= S_DATA;
         endcase
      end
   end

`ifdef JPEG_UNPACK_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stuff_cnt <= 16'h0000;
         fill_cnt  <= 16'h0000;
      end else if (accept && state_q == S_FF) begin
         if (in_data == STUFF_BYTE && stuff_cnt != 16'hFFFF) stuff_cnt <= stuff_cnt + 16'd1;
         if (in_data == MARKER_PFX && fill_cnt != 16'hFFFF)  fill_cnt  <= fill_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: rtl/jpeg_bitstream_unpacker.sv
// rtl/jpeg_bitstream_unpacker.sv - JPEG entropy-segment unpacker: unstuffed bit buffer with peek/consume
// Optional JPEG_UNPACK_STATS_EN exposes stuff_cnt/fill_cnt.
module jpeg_bitstream_unpacker
   import jpeg_unpack_pkg::*;
#(
   parameter int BUF_W  = BUF_W_DEF,
   parameter int PEEK_W = PEEK_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [PEEK_W-1:0] peek_data,
   output logic              peek_valid,
   output logic [CNT_W-1:0]  avail,
   input  logic              consume_en,
   input  logic [4:0]        consume_len,
   output logic              marker_found,
   output logic [7:0]        marker_code,
   input  logic              marker_clr,
`ifdef JPEG_UNPACK_STATS_EN
   output logic [15:0]       stuff_cnt,
   output logic [15:0]       fill_cnt,
`endif
   output logic              err
);

   logic              live_q;
   logic [BUF_W-1:0]  buf_q;
   logic [CNT_W-1:0]  avail_q;
   logic [CNT_W-1:0]  len_ext;
   logic [CNT_W-1:0]  len;
   logic [CNT_W-1:0]  rem;
   logic [BUF_W-1:0]  shifted;
   logic [BUF_W-1:0]  app_vec;
   logic              space_ok;
   logic              cons_ok;
   logic              app_valid;
   logic [7:0]        app_byte;

   jpeg_unstuff_fsm u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .rx_en        (live_q && space_ok),
      .marker_clr   (marker_clr),
      .in_ready     (in_ready),
      .app_valid    (app_valid),
      .app_byte     (app_byte),
      .marker_found (marker_found),
`ifdef JPEG_UNPACK_STATS_EN
      .stuff_cnt    (stuff_cnt),
      .fill_cnt     (fill_cnt),
`endif
      .marker_code  (marker_code)
   );

   // Buffer is MSB-aligned; bits at or beyond avail_q are kept zero so appends can simply OR in.
   assign space_ok = (avail_q <= CNT_W'(BUF_W - 8));
   assign len_ext  = {{(CNT_W-5){1'b0}}, consume_len};
   assign cons_ok  = consume_en && (len_ext <= avail_q);
   assign len      = cons_ok ? len_ext : '0;
   assign rem      = avail_q - len;
   assign shifted  = buf_q << len;
   assign app_vec  = {app_byte, {(BUF_W-8){1'b0}}} >> rem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q  <= 1'b0;
         buf_q   <= '0;
         avail_q <= '0;
         err     <= 1'b0;
      end else begin
         live_q <= 1'b1;
         if (consume_en && !cons_ok) err <= 1'b1;
         if (app_valid) begin
            buf_q   <= shifted | app_vec;
            avail_q <= rem + CNT_W'(8);
         end else begin
            buf_q   <= shifted;
            avail_q <= rem;
         end
      end
   end

   // Missing bits read as 1 so a flush at a marker sees JPEG padding.
   assign peek_data  = live_q ? (buf_q[BUF_W-1 -: PEEK_W] | ({PEEK_W{1'b1}} >> avail_q)) : '0;
   assign peek_valid = (avail_q >= CNT_W'(PEEK_W)) || marker_found;
   assign avail      = avail_q;

endmodule

// File: tb/tb_jpeg_bitstream_unpacker.sv
// tb/tb_jpeg_bitstream_unpacker.sv - directed self-checking bench for jpeg_bitstream_unpacker
module tb_jpeg_bitstream_unpacker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] peek_data;
   logic        peek_valid;
   logic [5:0]  avail;
   logic        consume_en = 1'b0;
   logic [4:0]  consume_len = 5'd0;
   logic        marker_found;
   logic [7:0]  marker_code;
   logic        marker_clr = 1'b0;
   logic        err;
`ifdef JPEG_UNPACK_STATS_EN
   logic [15:0] stuff_cnt;
   logic [15:0] fill_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   jpeg_bitstream_unpacker dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .peek_data    (peek_data),
      .peek_valid   (peek_valid),
      .avail        (avail),
      .consume_en   (consume_en),
      .consume_len  (consume_len),
      .marker_found (marker_found),
      .marker_code  (marker_code),
      .marker_clr   (marker_clr),
`ifdef JPEG_UNPACK_STATS_EN
      .stuff_cnt    (stuff_cnt),
      .fill_cnt     (fill_cnt),
`endif
      .err          (err)
   );

   // All stimulus starts and ends 1 time unit after a rising edge.
   task automatic send(input logic [7:0] b);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      n_checks++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL send_timeout byte %h: in_ready got 0 want 1", b);
      end else begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic consume(input int n);
      consume_en  = 1'b1;
      consume_len = 5'(n);
      @(posedge clk); #1;
      consume_en  = 1'b0;
      consume_len = 5'd0;
   endtask

   task automatic pulse_clr();
      marker_clr = 1'b1;
      @(posedge clk); #1;
      marker_clr = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (in_ready !== 1'b0)      begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
      n_checks++; if (avail !== 6'd0)         begin n_fail++; $display("FAIL rst_avail got %0d want 0", avail); end
      n_checks++; if (peek_data !== 16'h0000) begin n_fail++; $display("FAIL rst_peek got %h want 0000", peek_data); end
      n_checks++; if (peek_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_peek_valid got %b want 0", peek_valid); end
      n_checks++; if (marker_found !== 1'b0)  begin n_fail++; $display("FAIL rst_marker got %b want 0", marker_found); end
      n_checks++; if (marker_code !== 8'h00)  begin n_fail++; $display("FAIL rst_code got %h want 00", marker_code); end
      n_checks++; if (err !== 1'b0)           begin n_fail++; $display("FAIL rst_err got %b want 0", err); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      send(8'hA5);
      send(8'h3C);
      n_checks++; if (avail !== 6'd16)        begin n_fail++; $display("FAIL basic_avail got %0d want 16", avail); end
      n_checks++; if (peek_data !== 16'hA53C) begin n_fail++; $display("FAIL basic_peek got %h want a53c", peek_data); end
      n_checks++; if (peek_valid !== 1'b1)    begin n_fail++; $display("FAIL basic_peek_valid got %b want 1", peek_valid); end
      consume(4);
      n_checks++; if (peek_data !== 16'h53CF) begin n_fail++; $display("FAIL basic_c4_peek got %h want 53cf", peek_data); end
      n_checks++; if (avail !== 6'd12)        begin n_fail++; $display("FAIL basic_c4_avail got %0d want 12", avail); end
      n_checks++; if (peek_valid !== 1'b0)    begin n_fail++; $display("FAIL basic_c4_peek_valid got %b want 0", peek_valid); end
      consume(0);
      n_checks++; if (avail !== 6'd12)        begin n_fail++; $display("FAIL basic_c0_avail got %0d want 12", avail); end
      consume(12);
      n_checks++; if (avail !== 6'd0)         begin n_fail++; $display("FAIL basic_drain got %0d want 0", avail); end
   endtask

   task automatic test_unstuff();
      send(8'hFF);
      n_checks++; if (avail !== 6'd0)         begin n_fail++; $display("FAIL stuff_ff_avail got %0d want 0", avail); end
      send(8'h00);
      send(8'h12);
      n_checks++; if (avail !== 6'd16)        begin n_fail++; $display("FAIL stuff_avail got %0d want 16", avail); end
      n_checks++; if (peek_data !== 16'hFF12) begin n_fail++; $display("FAIL stuff_peek got %h want ff12", peek_data); end
`ifdef JPEG_UNPACK_STATS_EN
      n_checks++; if (stuff_cnt !== 16'd1)    begin n_fail++; $display("FAIL stuff_cnt got %0d want 1", stuff_cnt); end
`endif
      consume(16);
   endtask

   task automatic test_marker();
      send(8'hFF);
      send(8'hFF);
      send(8'hFF);
      send(8'hD9);
      n_checks++; if (marker_found !== 1'b1) begin n_fail++; $display("FAIL mk_found got %b want 1", marker_found); end
      n_checks++; if (marker_code !== 8'hD9) begin n_fail++; $display("FAIL mk_code got %h want d9", marker_code); end
      n_checks++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL mk_in_ready got %b want 0", in_ready); end
      n_checks++; if (avail !== 6'd0)        begin n_fail++; $display("FAIL mk_avail got %0d want 0", avail); end
      n_checks++; if (peek_valid !== 1'b1)   begin n_fail++; $display("FAIL mk_peek_valid got %b want 1", peek_valid); end
`ifdef JPEG_UNPACK_STATS_EN
      n_checks++; if (fill_cnt !== 16'd2)    begin n_fail++; $display("FAIL fill_cnt got %0d want 2", fill_cnt); end
`endif
      pulse_clr();
      n_checks++; if (marker_found !== 1'b0) begin n_fail++; $display("FAIL mk_clr_found got %b want 0", marker_found); end
      n_checks++; if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL mk_clr_in_ready got %b want 1", in_ready); end
      n_checks++; if (marker_code !== 8'hD9) begin n_fail++; $display("FAIL mk_clr_code got %h want d9", marker_code); end
   endtask

   task automatic test_back_to_back();
      send(8'h12);
      send(8'h34);
      send(8'h56);
      n_checks++; if (avail !== 6'd24)   begin n_fail++; $display("FAIL b2b_avail24 got %0d want 24", avail); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready24 got %b want 1", in_ready); end
      in_data = 8'h78; in_valid = 1'b1; consume_en = 1'b1; consume_len = 5'd7;
      @(posedge clk); #1;
      in_valid = 1'b0; consume_en = 1'b0; consume_len = 5'd0;
      n_checks++; if (avail !== 6'd25)        begin n_fail++; $display("FAIL b2b_avail got %0d want 25", avail); end
      n_checks++; if (peek_data !== 16'h1A2B) begin n_fail++; $display("FAIL b2b_peek got %h want 1a2b", peek_data); end
      n_checks++; if (in_ready !== 1'b0)      begin n_fail++; $display("FAIL b2b_ready25 got %b want 0", in_ready); end
      consume(16);
      n_checks++; if (avail !== 6'd9)         begin n_fail++; $display("FAIL b2b_c16_avail got %0d want 9", avail); end
      n_checks++; if (peek_data !== 16'h3C7F) begin n_fail++; $display("FAIL b2b_c16_peek got %h want 3c7f", peek_data); end
   endtask

   task automatic test_err();
      consume(4);
      n_checks++; if (avail !== 6'd5)         begin n_fail++; $display("FAIL err_pre_avail got %0d want 5", avail); end
      n_checks++; if (err !== 1'b0)           begin n_fail++; $display("FAIL err_pre got %b want 0", err); end
      consume(9);
      n_checks++; if (err !== 1'b1)           begin n_fail++; $display("FAIL err_set got %b want 1", err); end
      n_checks++; if (avail !== 6'd5)         begin n_fail++; $display("FAIL err_avail got %0d want 5", avail); end
      n_checks++; if (peek_data !== 16'hC7FF) begin n_fail++; $display("FAIL err_peek got %h want c7ff", peek_data); end
      consume(5);
      n_checks++; if (err !== 1'b1)           begin n_fail++; $display("FAIL err_sticky got %b want 1", err); end
   endtask

   task automatic test_flush();
      send(8'h05);
      consume(5);
      send(8'hFF);
      send(8'hD0);
      n_checks++; if (avail !== 6'd3)         begin n_fail++; $display("FAIL flush_avail got %0d want 3", avail); end
      n_checks++; if (peek_valid !== 1'b1)    begin n_fail++; $display("FAIL flush_peek_valid got %b want 1", peek_valid); end
      n_checks++; if (peek_data !== 16'hBFFF) begin n_fail++; $display("FAIL flush_peek got %h want bfff", peek_data); end
      n_checks++; if (marker_code !== 8'hD0)  begin n_fail++; $display("FAIL flush_code got %h want d0", marker_code); end
      pulse_clr();
      consume(3);
   endtask

   task automatic test_reset_mid();
      send(8'hAB);
      send(8'hCD);
      consume(4);
      send(8'hFF);
      n_checks++; if (avail !== 6'd12) begin n_fail++; $display("FAIL mid_avail got %0d want 12", avail); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (avail !== 6'd0)         begin n_fail++; $display("FAIL mid_rst_avail got %0d want 0", avail); end
      n_checks++; if (peek_data !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_peek got %h want 0000", peek_data); end
      n_checks++; if (peek_valid !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_pv got %b want 0", peek_valid); end
      n_checks++; if (in_ready !== 1'b0)      begin n_fail++; $display("FAIL mid_rst_ready got %b want 0", in_ready); end
      n_checks++; if (err !== 1'b0)           begin n_fail++; $display("FAIL mid_rst_err got %b want 0", err); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      send(8'h00);
      n_checks++; if (avail !== 6'd8)         begin n_fail++; $display("FAIL mid_fresh_avail got %0d want 8", avail); end
      n_checks++; if (peek_data !== 16'h00FF) begin n_fail++; $display("FAIL mid_fresh_peek got %h want 00ff", peek_data); end
`ifdef JPEG_UNPACK_STATS_EN
      n_checks++; if (stuff_cnt !== 16'd0)    begin n_fail++; $display("FAIL mid_stuff_cnt got %0d want 0", stuff_cnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_unstuff();
      test_marker();
      test_back_to_back();
      test_err();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
